// File: rtl/fetch_queue.sv
// Instruction-fetch front end: walks the fetch PC, issues single outstanding
// requests to instruction memory and queues {word, pc+4} for the decode stage.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clock,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc4
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} stateT;

    stateT             state;
    stateT             nextState;
    logic [31:0]       fpc;
    logic [31:0]       tagPc4;
    logic [31:0]       wordMem [DEPTH];
    logic [31:0]       pc4Mem  [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [CNT_W-1:0]  count;
    logic              accept;
    logic              push;
    logic              pop;
    logic              unusedBits;

    assign unusedBits = ^redirect_pc[1:0];

    // Redirect never blocks an in-flight response from arriving, so an accepted
    // request that gets flushed must be drained through DROP before refetching.
    always_comb begin
        nextState = state;
        accept    = 1'b0;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (!redirect && (count < CNT_W'(DEPTH)))
                    nextState = REQ;
            end
            REQ: begin
                accept = imem_ack;
                if (imem_ack)
                    nextState = redirect ? DROP : WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    push      = !redirect;
                    nextState = IDLE;
                end else if (redirect) begin
                    nextState = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid)
                    nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    assign pop = instr_valid && id_ready && !redirect;

    always_ff @(posedge clock or posedge start) begin
        if (start)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_ff @(posedge clock or posedge start) begin
        if (start) begin
            fpc    <= RESET_PC;
            tagPc4 <= 32'h0;
        end else if (redirect) begin
            fpc <= {redirect_pc[31:2], 2'b00};
        end else if (accept) begin
            fpc    <= fpc + 32'd4;
            tagPc4 <= fpc + 32'd4;
        end
    end

    always_ff @(posedge clock or posedge start) begin
        if (start) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (redirect) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push)
                wrPtr <= wrPtr + PTR_W'(1);
            if (pop)
                rdPtr <= rdPtr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    // Storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge clock) begin
        if (push) begin
            wordMem[wrPtr] <= imem_rdata;
            pc4Mem[wrPtr]  <= tagPc4;
        end
    end

    assign imem_req    = (state == REQ);
    assign imem_addr   = fpc;
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? wordMem[rdPtr] : 32'h0;
    assign instr_pc4   = instr_valid ? pc4Mem[rdPtr]  : 32'h0;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: behavioural memory, a scoreboard of
// expected queue entries, a redirect vector table and multi-cycle corner cases.
module tb_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'hFFFFFFF8;
    localparam logic [31:0] XOR_KEY  = 32'hA5A5A5A5;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc4;
    } sbEntryT;

    typedef struct {
        logic [31:0] redirectPc;
        logic [31:0] expAddr;
        logic [31:0] expPc4;
        logic        holdResp;
    } vecT;

    logic        clock = 1'b0;
    logic        start = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_ready = 1'b1;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc4;

    logic        memAuto = 1'b1;
    logic        ackEn = 1'b1;
    logic        rvalidEn = 1'b1;
    logic        manualAck = 1'b0;
    logic        manualRvalid = 1'b0;
    logic        pendValid = 1'b0;
    logic [31:0] pendAddr = 32'h0;

    logic        obsReq = 1'b0;
    logic [31:0] obsAddr = 32'h0;
    logic        obsValid = 1'b0;
    logic [31:0] obsInstr = 32'h0;
    logic [31:0] obsPc4 = 32'h0;

    sbEntryT     sbQ[$];
    logic [31:0] acceptLog[$];
    logic [31:0] deliveredPc4[$];

    int vectors = 0;
    int miscompares = 0;

    fetch_queue #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
        .clock(clock),
        .start(start),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .id_ready(id_ready),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_pc4(instr_pc4)
    );

    always #5 clock = ~clock;

    // Memory and scoreboard advance on each edge using the outputs observed at
    // the preceding negedge; new memory inputs are driven 1ns after the edge.
    always @(posedge clock) begin : memModel
        sbEntryT headEntry;
        if (imem_rvalid)
            pendValid = 1'b0;
        if (!start && obsReq && imem_ack) begin
            pendValid = 1'b1;
            pendAddr  = obsAddr;
            sbQ.push_back('{obsAddr ^ XOR_KEY, obsAddr + 32'd4});
            acceptLog.push_back(obsAddr);
        end
        if (start || redirect) begin
            sbQ.delete();
        end else if (obsValid && id_ready) begin
            if (sbQ.size() != 0)
                headEntry = sbQ.pop_front();
            deliveredPc4.push_back(obsPc4);
        end
        #1;
        imem_ack    = memAuto ? ackEn : manualAck;
        imem_rvalid = memAuto ? (pendValid && rvalidEn) : manualRvalid;
        imem_rdata  = memAuto ? (pendAddr ^ XOR_KEY) : 32'hDEADBEEF;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic redirectIn, input logic [31:0] pcIn, input logic readyIn);
        redirect    = redirectIn;
        redirect_pc = pcIn;
        id_ready    = readyIn;
    endtask

    // Every step samples the DUT mid-cycle and checks the queue head against the scoreboard.
    task automatic tick();
        @(negedge clock);
        obsReq   = imem_req;
        obsAddr  = imem_addr;
        obsValid = instr_valid;
        obsInstr = instr;
        obsPc4   = instr_pc4;
        checkOutput("addrAlign", {30'b0, obsAddr[1:0]}, 32'h0);
        if (obsValid) begin
            checkOutput("sbHasEntry", {31'b0, sbQ.size() != 0}, 32'h1);
            if (sbQ.size() != 0) begin
                checkOutput("headInstr", obsInstr, sbQ[0].word);
                checkOutput("headPc4", obsPc4, sbQ[0].pc4);
            end
        end else begin
            checkOutput("emptyInstr", obsInstr, 32'h0);
            checkOutput("emptyPc4", obsPc4, 32'h0);
        end
    endtask

    task automatic waitAccepts(input int n, input int budget);
        int i = 0;
        while (acceptLog.size() < n && i < budget) begin
            tick();
            i++;
        end
        checkOutput("acceptTimeout", {31'b0, acceptLog.size() >= n}, 32'h1);
    endtask

    task automatic waitDeliveries(input int n, input int budget);
        int i = 0;
        while (deliveredPc4.size() < n && i < budget) begin
            tick();
            i++;
        end
        checkOutput("deliverTimeout", {31'b0, deliveredPc4.size() >= n}, 32'h1);
    endtask

    task automatic waitPending(input int budget);
        int i = 0;
        do begin
            tick();
            i++;
        end while (!pendValid && i < budget);
        checkOutput("pendTimeout", {31'b0, pendValid}, 32'h1);
    endtask

    task automatic waitReq(input int budget);
        int i = 0;
        do begin
            tick();
            i++;
        end while (!obsReq && i < budget);
        checkOutput("reqTimeout", {31'b0, obsReq}, 32'h1);
    endtask

    initial begin
        vecT vecs[5];
        int  base;
        int  dbase;

        vecs[0] = '{32'h00000103, 32'h00000100, 32'h00000104, 1'b1};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000000, 1'b1};
        vecs[2] = '{32'h12345678, 32'h12345678, 32'h1234567C, 1'b0};
        vecs[3] = '{32'h00000002, 32'h00000000, 32'h00000004, 1'b0};
        vecs[4] = '{32'h00000ABD, 32'h00000ABC, 32'h00000AC0, 1'b1};

        // Reset values, first-fetch latency and wrap of the PC past 2^32.
        tick();
        tick();
        checkOutput("rstReq", {31'b0, obsReq}, 32'h0);
        checkOutput("rstAddr", obsAddr, RESET_PC);
        checkOutput("rstValid", {31'b0, obsValid}, 32'h0);
        start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (i == 1) begin
                checkOutput("firstReq", {31'b0, obsReq}, 32'h1);
                checkOutput("firstAddr", obsAddr, RESET_PC);
            end
            checkOutput("firstValid", {31'b0, obsValid}, {31'b0, i == 3});
        end
        waitDeliveries(3, 30);
        checkOutput("wrapAddr0", acceptLog[0], 32'hFFFFFFF8);
        checkOutput("wrapAddr1", acceptLog[1], 32'hFFFFFFFC);
        checkOutput("wrapAddr2", acceptLog[2], 32'h00000000);
        checkOutput("wrapPc4_0", deliveredPc4[0], 32'hFFFFFFFC);
        checkOutput("wrapPc4_1", deliveredPc4[1], 32'h00000000);
        checkOutput("wrapPc4_2", deliveredPc4[2], 32'h00000004);

        // Decode stalled: exactly DEPTH fetches, then requests stop until pops resume.
        applyStimulus(1'b1, 32'h0, 1'b0);
        tick();
        base = acceptLog.size();
        applyStimulus(1'b0, 32'h0, 1'b0);
        repeat (40) tick();
        checkOutput("fullAccepts", acceptLog.size() - base, 32'd4);
        checkOutput("fullLastAddr", acceptLog[base + 3], 32'd12);
        checkOutput("fullReqIdle", {31'b0, obsReq}, 32'h0);
        checkOutput("fullValid", {31'b0, obsValid}, 32'h1);
        dbase = deliveredPc4.size();
        applyStimulus(1'b0, 32'h0, 1'b1);
        waitDeliveries(dbase + 4, 40);
        checkOutput("drainPc4First", deliveredPc4[dbase], 32'd4);
        checkOutput("drainPc4Last", deliveredPc4[dbase + 3], 32'd16);
        waitAccepts(base + 5, 20);
        checkOutput("resumeAddr", acceptLog[base + 4], 32'd16);

        // Redirect table: optionally parked in WAIT so the in-flight word must be dropped.
        for (int v = 0; v < 5; v++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
            if (vecs[v].holdResp) begin
                rvalidEn = 1'b0;
                waitPending(20);
            end else begin
                repeat ($urandom_range(3)) tick();
            end
            applyStimulus(1'b1, vecs[v].redirectPc, 1'b1);
            tick();
            base  = acceptLog.size();
            dbase = deliveredPc4.size();
            applyStimulus(1'b0, 32'h0, 1'b1);
            checkOutput("redirFlush", {31'b0, obsValid}, 32'h0);
            rvalidEn = 1'b1;
            waitAccepts(base + 1, 20);
            checkOutput("redirAddr", acceptLog[base], vecs[v].expAddr);
            waitDeliveries(dbase + 1, 20);
            checkOutput("redirPc4", deliveredPc4[dbase], vecs[v].expPc4);
        end

        // Redirect while the request is still unacknowledged retargets it in place.
        ackEn = 1'b0;
        tick();
        waitReq(20);
        applyStimulus(1'b1, 32'h00000201, 1'b1);
        tick();
        checkOutput("retargetReq", {31'b0, obsReq}, 32'h1);
        checkOutput("retargetAddr", obsAddr, 32'h00000200);
        applyStimulus(1'b0, 32'h0, 1'b1);
        base  = acceptLog.size();
        dbase = deliveredPc4.size();
        tick();
        checkOutput("noDropReq", {31'b0, obsReq}, 32'h1);
        checkOutput("noDropAddr", obsAddr, 32'h00000200);
        ackEn = 1'b1;
        waitAccepts(base + 1, 20);
        checkOutput("retargetAccept", acceptLog[base], 32'h00000200);
        waitDeliveries(dbase + 1, 20);
        checkOutput("retargetPc4", deliveredPc4[dbase], 32'h00000204);

        // Reset mid-WAIT with stray responses during and just after reset.
        rvalidEn = 1'b0;
        waitPending(20);
        memAuto      = 1'b0;
        manualAck    = 1'b0;
        manualRvalid = 1'b0;
        start        = 1'b1;
        tick();
        checkOutput("midRstValid", {31'b0, obsValid}, 32'h0);
        checkOutput("midRstReq", {31'b0, obsReq}, 32'h0);
        checkOutput("midRstAddr", obsAddr, RESET_PC);
        manualRvalid = 1'b1;
        tick();
        checkOutput("rstRvalidValid", {31'b0, obsValid}, 32'h0);
        start = 1'b0;
        base  = acceptLog.size();
        dbase = deliveredPc4.size();
        tick();
        checkOutput("lateRvalidValid", {31'b0, obsValid}, 32'h0);
        manualRvalid = 1'b0;
        tick();
        checkOutput("restartValid", {31'b0, obsValid}, 32'h0);
        checkOutput("restartReq", {31'b0, obsReq}, 32'h1);
        checkOutput("restartAddr", obsAddr, RESET_PC);
        memAuto  = 1'b1;
        rvalidEn = 1'b1;
        waitAccepts(base + 1, 20);
        checkOutput("restartAccept", acceptLog[base], RESET_PC);
        waitDeliveries(dbase + 1, 20);
        checkOutput("restartPc4", deliveredPc4[dbase], 32'hFFFFFFFC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
